// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the program memory and the CPU side:
//            FSM state encoding, default geometry and bus read/write encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 16;

  // rw_enable encoding on the CPU memory bus (write is active-low)
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_core.sv
`default_nettype none
// ============================================================================
// Module   : ram_core
// Purpose  : Word store with one asynchronous read port and one synchronous
//            write port. Contents are never cleared.
// Ports    : clk        - write clock (rising edge)
//            we         - write enable
//            waddr      - write address
//            wdata      - write data
//            raddr      - read address
//            rdata      - read data, combinational from raddr
// Revision : 1.0 - initial release
// ============================================================================
module ram_core #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read so the CPU can fetch in a single cycle
  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/program_memory.sv
`default_nettype none
// ============================================================================
// Module   : program_memory
// Purpose  : Memory-side responder for the CPU single-cycle bus with a
//            boot-load FSM. In LOAD the store is filled from a valid/ready
//            word stream while the CPU is held in reset; in RUN the CPU reads
//            combinationally and writes synchronously.
// Ports    : clk, reset      - clock / async active-high reset
//            address         - CPU word address
//            rw_enable       - 0 = write data_in, 1 = read
//            data_in         - CPU write data
//            data_out        - CPU read data (0 while loading)
//            load_start      - pulse: restart loading from address 0
//            load_valid      - loader word valid
//            load_data       - loader word
//            load_last       - final loader word marker
//            load_ready      - loader word accepted this cycle
//            cpu_reset       - CPU reset, high while not in RUN
//            load_count      - words accepted in current/last load
// Revision : 1.0 - initial release
// ============================================================================
module program_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  rw_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_ptr_q, load_ptr_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // --------------------------------------------------------------------------
  // State / pointer registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD;
      load_ptr_q   <= '0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      load_count_q <= load_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and write-port mux
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count_q;
    mem_we       = 1'b0;
    mem_waddr    = load_ptr_q;
    mem_wdata    = load_data;

    case (state_q)
      LOAD: begin
        // load_ready is constant 1 here, so load_valid alone is the handshake
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
        end
        if (load_start) begin
          // Restart wins over a concurrent handshake: that word goes to 0
          mem_waddr = '0;
          if (load_valid) begin
            load_ptr_d   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            load_count_d = {{ADDR_WIDTH{1'b0}}, 1'b1};
          end else begin
            load_ptr_d   = '0;
            load_count_d = '0;
          end
        end else if (load_valid) begin
          mem_waddr    = load_ptr_q;
          load_count_d = load_count_q + 1'b1;
          if (load_last || (load_ptr_q == LAST_ADDR)) begin
            state_d    = RUN;
            load_ptr_d = '0;
          end else begin
            load_ptr_d = load_ptr_q + 1'b1;
          end
        end
      end

      RUN: begin
        mem_we    = (rw_enable == RW_WRITE);
        mem_waddr = address;
        mem_wdata = data_in;
        if (load_start) begin
          state_d      = LOAD;
          load_ptr_d   = '0;
          load_count_d = '0;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram_core (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (address),
    .rdata (mem_rdata)
  );

  assign load_ready = (state_q == LOAD);
  assign cpu_reset  = (state_q != RUN);
  assign data_out   = (state_q == RUN) ? mem_rdata : '0;
  assign load_count = load_count_q;

endmodule
`default_nettype wire

// File: doc/program_memory.md
Name: program_memory

Overview:
- Memory-side responder for the CPU's single-cycle memory bus (address / rw_enable / data_in / data_out).
- Holds a 2^ADDR_WIDTH x DATA_WIDTH word store that serves instruction fetch, CPU reads and CPU writes.
- Contains a boot-load FSM that fills the store from a valid/ready word stream while holding the CPU in reset, then releases the CPU.
- Sits beside the CPU in the top level; the loader stream comes from the host/debug link.

Parameters:
ADDR_WIDTH, 8, CPU address width; depth = 2^ADDR_WIDTH words
DATA_WIDTH, 16, word width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
address  input  ADDR_WIDTH  CPU word address
rw_enable  input  1  active-low write enable: 0 = write data_in, 1 = read
data_in  input  DATA_WIDTH  CPU write data
data_out  output  DATA_WIDTH  read data to CPU (instruction/operand)
load_start  input  1  one-cycle pulse: (re)enter LOAD from address 0
load_valid  input  1  loader word valid
load_data  input  DATA_WIDTH  loader word
load_last  input  1  marks final loader word, qualified by load_valid
load_ready  output  1  memory accepts loader word this cycle
cpu_reset  output  1  active-high reset to CPU; high while not RUN
load_count  output  ADDR_WIDTH+1  words accepted in current/last load

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- States: LOAD, RUN. Reset forces LOAD with load_ptr=0 and load_count=0.
- Reset values: cpu_reset=1, load_ready=1, data_out=0. Memory contents are not cleared by reset.
- LOAD state:
  - load_ready=1; cpu_reset=1; data_out=0.
  - CPU rw_enable/data_in are ignored; no CPU writes occur.
  - Handshake: a word transfers on a rising edge with load_valid && load_ready. The word is written to mem[load_ptr], then load_ptr+1 and load_count+1.
  - load_valid low: nothing changes. load_data and load_last are don't-care.
- LOAD -> RUN on the transfer edge when load_last=1, or when load_ptr = 2^ADDR_WIDTH-1 (wrap: the last location is written and the FSM enters RUN; load_count = 2^ADDR_WIDTH).
  - load_ptr returns to 0 on the transition.
  - cpu_reset falls in the first RUN cycle, so the CPU fetches from address 0 on the following edge.
- RUN state:
  - load_ready=0; cpu_reset=0.
  - Read is combinational, zero latency: data_out = mem[address] in the same cycle. This is required for single-cycle fetch.
  - Write: rw_enable=0 writes data_in to mem[address] on the rising edge. During the write cycle, data_out shows the old contents; the new value is visible from the next cycle.
  - load_valid is ignored in RUN.
- load_start:
  - In RUN: next edge enters LOAD, load_ptr=0, load_count=0, cpu_reset=1. Any CPU write in that same cycle is still performed.
  - In LOAD: restarts with load_ptr=0 and load_count=0. If a handshake occurs in the same cycle, load_start wins: the word is written to address 0 and load_ptr=1, load_count=1.
- Reset mid-load: returns to LOAD at address 0. Already-written words persist.
- load_count holds its value through RUN until the next load_start or reset.
- Address arithmetic is unsigned, modulo 2^ADDR_WIDTH; load_count is one bit wider.

Decomposition:
- Shared package mem_pkg holds:
  - state enum {LOAD, RUN}
  - default ADDR_WIDTH/DATA_WIDTH constants
  - RW_WRITE=1'b0 / RW_READ=1'b1 encodings, shared with the CPU side
- Sub-module ram_core: storage array with one async read port and one sync write port.
- program_memory contains the FSM, load pointer/counter and the write-port mux (loader in LOAD, CPU in RUN).

Test Plan:
- Reset, then stream 0x1111, 0x2222, 0x3333 with last on the third word -> load_count=3, cpu_reset falls one cycle after the third handshake; in RUN, address 0/1/2 reads 0x1111/0x2222/0x3333 combinationally.
- In RUN, rw_enable=0, address=0x10, data_in=0xBEEF -> data_out shows the old value in that cycle; the next cycle with rw_enable=1 reads 0xBEEF. load_valid=1 during RUN has no effect.
- Stream 256 words (value = index), never assert last -> auto RUN after word 255; load_count=256; mem[255]=0x00FF.
- Assert reset after 5 loader words, then load 2 words with last -> mem[0..1] hold the new words, mem[2..4] keep the old words, load_count=2.
- In RUN pulse load_start -> cpu_reset=1 and load_ready=1 next cycle; CPU writes are ignored in LOAD. Pulse load_start together with a handshake mid-load -> that word lands at address 0 and load_count=1.
- Loader holds load_valid low for 10 cycles mid-stream -> load_ptr and load_count are stable and the FSM stays in LOAD.
